fft_r2sdf_bf: RTL and testbench



---
 rtl/fft_r2sdf_bf.sv | 136 +++++++++++++
 tb/tb_fft_r2sdf_bf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r2sdf_bf.sv
// fft_r2sdf_bf: radix-2 single-path delay-feedback butterfly stage.
// Routes samples through an external LEN-deep delay line, forms sum/difference
// butterflies and emits one registered complex sample per clock, with
// frame counter, IDLE/FILL/RUN sequencing and frame-start marking.
// Optional build macro: FFT_R2SDF_BF_SCALE_EN scales sums and differences by
// 1/2 with round-half-up before storage/output.
module fft_r2sdf_bf #(
    parameter int DATA_WIDTH = 25,
    parameter int LEN        = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] xr_i,
    input  logic signed [DATA_WIDTH-1:0] xi_i,
    input  logic signed [DATA_WIDTH:0]   delay_r_i,
    input  logic signed [DATA_WIDTH:0]   delay_i_i,
    output logic signed [DATA_WIDTH:0]   delay_r_o,
    output logic signed [DATA_WIDTH:0]   delay_i_o,
    output logic signed [DATA_WIDTH:0]   zr_o,
    output logic signed [DATA_WIDTH:0]   zi_o,
    output logic                         valid_o,
    output logic                         frame_start_o
);

    localparam int CW = $clog2(LEN) + 1;
    localparam int OW = DATA_WIDTH + 1;
    localparam int AW = DATA_WIDTH + 2;
    localparam logic [CW-1:0]        LAST_FILL = CW'(LEN - 1);
    localparam logic [CW-1:0]        FIRST_SUM = CW'(LEN);
    localparam logic [CW-1:0]        CTR_ONE   = CW'(1);
    localparam logic signed [AW-1:0] ONE       = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_ctr;
    logic [CW-1:0]  w_ctr_nxt;

    logic                 w_phase;
    logic                 w_out_en;
    logic signed [AW-1:0] w_ar, w_br, w_ai, w_bi;
    logic signed [OW-1:0] w_sum_r, w_dif_r, w_sum_i, w_dif_i;
    logic signed [OW-1:0] w_ext_r, w_ext_i;
    logic signed [OW-1:0] w_cand_r, w_cand_i;

    // Result is exact at AW bits; narrowing to OW is lossless because one
    // operand is always a sign-extended DATA_WIDTH value.
    function automatic logic signed [OW-1:0] f_fit(input logic signed [AW-1:0] v);
`ifdef FFT_R2SDF_BF_SCALE_EN
        return OW'((v + ONE) >>> 1);
`else
        return OW'(v);
`endif
    endfunction

    // State register and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ctr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctr   <= w_ctr_nxt;
        end
    end

    // Next-state and next-count logic; a dropped valid always wins
    always_comb begin
        w_state_nxt = r_state;
        w_ctr_nxt   = r_ctr + CTR_ONE;
        if (!valid_i) begin
            w_state_nxt = S_IDLE;
            w_ctr_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_FILL;
                S_FILL:  w_state_nxt = (r_ctr == LAST_FILL) ? S_RUN : S_FILL;
                S_RUN:   w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Butterfly datapath and delay-line routing
    always_comb begin
        w_phase  = r_ctr[CW-1];
        w_out_en = valid_i && (r_state == S_RUN);
        w_ext_r  = {xr_i[DATA_WIDTH-1], xr_i};
        w_ext_i  = {xi_i[DATA_WIDTH-1], xi_i};
        w_ar     = {delay_r_i[OW-1], delay_r_i};
        w_ai     = {delay_i_i[OW-1], delay_i_i};
        w_br     = {{2{xr_i[DATA_WIDTH-1]}}, xr_i};
        w_bi     = {{2{xi_i[DATA_WIDTH-1]}}, xi_i};
        w_sum_r  = f_fit(w_ar + w_br);
        w_dif_r  = f_fit(w_ar - w_br);
        w_sum_i  = f_fit(w_ai + w_bi);
        w_dif_i  = f_fit(w_ai - w_bi);
        if (w_phase) begin
            delay_r_o = w_dif_r;
            delay_i_o = w_dif_i;
            w_cand_r  = w_sum_r;
            w_cand_i  = w_sum_i;
        end else begin
            delay_r_o = w_ext_r;
            delay_i_o = w_ext_i;
            w_cand_r  = delay_r_i;
            w_cand_i  = delay_i_i;
        end
        // The start edge is taken from IDLE, so sample 0 must already be on
        // the delay-line input then; only an idle, non-valid cycle drives 0.
        if ((r_state == S_IDLE) && !valid_i) begin
            delay_r_o = '0;
            delay_i_o = '0;
        end
    end

    // Output register: butterfly result, valid and frame-start marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zr_o          <= '0;
            zi_o          <= '0;
            valid_o       <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            valid_o       <= w_out_en;
            frame_start_o <= w_out_en && (r_ctr == FIRST_SUM);
            if (w_out_en) begin
                zr_o <= w_cand_r;
                zi_o <= w_cand_i;
            end
        end
    end

endmodule

// File: tb/tb_fft_r2sdf_bf.sv
// tb_fft_r2sdf_bf: self-checking bench for fft_r2sdf_bf (DATA_WIDTH=8, LEN=4)
// with a behavioural LEN-cycle delay line and a stream-level output model.
module tb_fft_r2sdf_bf;

    localparam int DW  = 8;
    localparam int LEN = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid_i;
    logic signed [DW-1:0] xr_i, xi_i;
    logic signed [DW:0]   delay_r_i, delay_i_i;
    logic signed [DW:0]   delay_r_o, delay_i_o;
    logic signed [DW:0]   zr_o, zi_o;
    logic                 valid_o, frame_start_o;

    logic signed [DW:0]   dl_r [LEN];
    logic signed [DW:0]   dl_i [LEN];

    int checks   = 0;
    int failures = 0;
    int sr [64];
    int si [64];
    int obs_r [64];
    int obs_i [64];
    int last_r, last_i;

    fft_r2sdf_bf #(.DATA_WIDTH(DW), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i),
        .xr_i(xr_i), .xi_i(xi_i),
        .delay_r_i(delay_r_i), .delay_i_i(delay_i_i),
        .delay_r_o(delay_r_o), .delay_i_o(delay_i_o),
        .zr_o(zr_o), .zi_o(zi_o),
        .valid_o(valid_o), .frame_start_o(frame_start_o)
    );

    always #5 clk = ~clk;

    // Behavioural delay line: output equals input from exactly LEN edges ago
    always @(posedge clk) begin
        for (int i = LEN - 1; i > 0; i--) begin
            dl_r[i] <= dl_r[i-1];
            dl_i[i] <= dl_i[i-1];
        end
        dl_r[0] <= delay_r_o;
        dl_i[0] <= delay_i_o;
    end
    assign delay_r_i = dl_r[LEN-1];
    assign delay_i_i = dl_i[LEN-1];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int scl(input int v);
`ifdef FFT_R2SDF_BF_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    function automatic int smp(input bit im, input int k);
        return im ? si[k] : sr[k];
    endfunction

    // Output after capture of sample k: sums in the second half of each
    // 2*LEN frame, the matching differences one half-frame later.
    function automatic int exp_z(input bit im, input int k);
        if ((k % (2 * LEN)) >= LEN)
            return scl(smp(im, k - LEN) + smp(im, k));
        return scl(smp(im, k - 2 * LEN) - smp(im, k - LEN));
    endfunction

    function automatic int exp_dly(input bit im, input int k);
        if ((k % (2 * LEN)) < LEN)
            return smp(im, k);
        return scl(smp(im, k - LEN) - smp(im, k));
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            sr[k] = rnd8();
            si[k] = rnd8();
        end
    endtask

    task automatic run_stream(input int n);
        bit ev;
        for (int k = 0; k < n; k++) begin
            valid_i = 1'b1;
            xr_i    = DW'(sr[k]);
            xi_i    = DW'(si[k]);
            #1;
            chk("delay_r_o", delay_r_o, exp_dly(1'b0, k));
            chk("delay_i_o", delay_i_o, exp_dly(1'b1, k));
            @(posedge clk);
            #1;
            ev = (k >= LEN);
            chk("valid_o", valid_o, ev);
            chk("frame_start_o", frame_start_o, ev && ((k % (2 * LEN)) == LEN));
            if (ev) begin
                last_r = exp_z(1'b0, k);
                last_i = exp_z(1'b1, k);
            end
            chk("zr_o", zr_o, last_r);
            chk("zi_o", zi_o, last_i);
            obs_r[k] = int'($signed(zr_o));
            obs_i[k] = int'($signed(zi_o));
        end
    endtask

    task automatic drop_cycle();
        valid_i = 1'b0;
        xr_i    = DW'(rnd8());
        xi_i    = DW'(rnd8());
        @(posedge clk);
        #1;
        chk("drop.valid_o", valid_o, 0);
        chk("drop.frame_start_o", frame_start_o, 0);
        chk("drop.zr_hold", zr_o, last_r);
        chk("drop.zi_hold", zi_o, last_i);
        chk("idle.delay_r_o", delay_r_o, 0);
        chk("idle.delay_i_o", delay_i_o, 0);
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        xr_i    = '0;
        xi_i    = '0;
        last_r  = 0;
        last_i  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid_o", valid_o, 0);
        chk("rst.frame_start_o", frame_start_o, 0);
        chk("rst.zr_o", zr_o, 0);
        chk("rst.zi_o", zi_o, 0);
        chk("rst.delay_r_o", delay_r_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle.valid_o", valid_o, 0);

        // Ramp on real path, -3 / 5 halves on imaginary path
        for (int k = 0; k < 16; k++) begin
            sr[k] = k + 1;
            si[k] = ((k % 8) < 4) ? -3 : 5;
        end
        run_stream(16);
`ifndef FFT_R2SDF_BF_SCALE_EN
        chk("ramp.sum0", obs_r[4], 6);
        chk("ramp.sum3", obs_r[7], 12);
        chk("ramp.dif0", obs_r[8], -4);
        chk("ramp.frame2", obs_r[12], 22);
        chk("imag.sum", obs_i[4], 2);
        chk("imag.dif", obs_i[8], -8);
`endif
        drop_cycle();

        // Valid dropped when ctr = 6, then restart
        fill_random(6);
        run_stream(6);
        drop_cycle();
        fill_random(10);
        run_stream(10);
        drop_cycle();

        // Valid dropped on the FILL->RUN wrap edge, then restart
        fill_random(LEN - 1);
        run_stream(LEN - 1);
        drop_cycle();
        fill_random(9);
        run_stream(9);
        drop_cycle();

        // Full-scale operands
        fill_random(12);
        sr[0] = 127;  sr[1] = -128; sr[2] = 127;
        sr[4] = 127;  sr[5] = -128; sr[6] = -128;
        run_stream(12);
`ifndef FFT_R2SDF_BF_SCALE_EN
        chk("full.sum0", obs_r[4], 254);
        chk("full.sum1", obs_r[5], -256);
        chk("full.sum2", obs_r[6], -1);
        chk("full.dif0", obs_r[8], 0);
        chk("full.dif1", obs_r[9], 0);
        chk("full.dif2", obs_r[10], 255);
`endif
        drop_cycle();

`ifdef FFT_R2SDF_BF_SCALE_EN
        // Round-half-up halving
        fill_random(10);
        sr[0] = 3;  sr[1] = -3;
        sr[4] = 4;  sr[5] = -4;
        run_stream(10);
        chk("scale.sum_pos", obs_r[4], 4);
        chk("scale.sum_neg", obs_r[5], -3);
        chk("scale.dif_pos", obs_r[8], 0);
        chk("scale.dif_neg", obs_r[9], 1);
        drop_cycle();
`endif

        // Random streams of random length
        for (int t = 0; t < 5; t++) begin
            int n;
            n = int'($urandom_range(5, 40));
            fill_random(n);
            run_stream(n);
            drop_cycle();
        end

        // Asynchronous reset in the middle of RUN
        fill_random(10);
        run_stream(10);
        #2;
        rst     = 1'b1;
        valid_i = 1'b0;
        #1;
        chk("arst.valid_o", valid_o, 0);
        chk("arst.frame_start_o", frame_start_o, 0);
        chk("arst.zr_o", zr_o, 0);
        chk("arst.zi_o", zi_o, 0);
        last_r = 0;
        last_i = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill_random(12);
        run_stream(12);
        drop_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
